// File: rtl/irq_latch.sv
// Interrupt request front end. It synchronises three request lines and latches them as
// pending flags, using either rising-edge or level capture, for the IRQ priority encoder.
module irq_latch #(
    parameter int SYNC_STAGES = 2,   // legal range 2..4
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] REQ,
    input  logic [2:0] MASK,
    input  logic       ACK,
    input  logic [1:0] ACK_ID,
    output logic       IRQ3,
    output logic       IRQ2,
    output logic       IRQ1,
    output logic [2:0] PEND,
    output logic [2:0] OVF,
    output logic       ANY
);

    // ACK is a one-cycle strobe with no ready/valid handshake. ACK_ID names the line
    // (1..3, 0 = none). It takes effect at the next rising CLK edge.

    logic [2:0] r_sync [SYNC_STAGES];
    logic [2:0] r_pend;
    logic [2:0] r_ovf;
    logic [2:0] w_s;
    logic [2:0] w_clr;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 3'b000;
            end
        end else begin
            r_sync[0] <= REQ;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_clr = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_clr[i] = ACK && (ACK_ID == 2'(i + 1));
        end
    end

    generate
        if (EDGE_MODE) begin : g_edge
            logic [2:0] r_hist;
            logic [2:0] w_rise;

            assign w_rise = w_s & ~r_hist;

            // A rise that coincides with the ACK replaces the acknowledged event and
            // is not counted as an overrun.
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    r_hist <= 3'b000;
                    r_pend <= 3'b000;
                    r_ovf  <= 3'b000;
                end else begin
                    r_hist <= w_s;
                    for (int i = 0; i < 3; i++) begin
                        if (w_rise[i]) begin
                            if (!r_pend[i]) begin
                                r_pend[i] <= 1'b1;
                            end else if (!w_clr[i]) begin
                                r_ovf[i] <= 1'b1;
                            end
                        end else if (w_clr[i] && r_pend[i]) begin
                            r_pend[i] <= 1'b0;
                            r_ovf[i]  <= 1'b0;
                        end
                    end
                end
            end
        end else begin : g_level
            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    r_pend <= 3'b000;
                    r_ovf  <= 3'b000;
                end else begin
                    r_pend <= w_s;
                    r_ovf  <= 3'b000;
                end
            end
        end
    endgenerate

    assign IRQ3 = r_pend[2] & MASK[2];
    assign IRQ2 = r_pend[1] & MASK[1];
    assign IRQ1 = r_pend[0] & MASK[0];
    assign ANY  = IRQ3 | IRQ2 | IRQ1;
    assign PEND = r_pend;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_irq_latch.sv
// Directed bench for irq_latch. One instance uses edge mode and another uses level mode.
// Both instances share the same stimulus, and every expected value is written by hand.
module tb_irq_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] mask;
    logic       ack;
    logic [1:0] ack_id;

    logic       irq3_e, irq2_e, irq1_e, any_e;
    logic [2:0] pend_e, ovf_e;
    logic       irq3_l, irq2_l, irq1_l, any_l;
    logic [2:0] pend_l, ovf_l;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    irq_latch #(.SYNC_STAGES(2), .EDGE_MODE(1'b1)) u_dut_edge (
        .CLK(clk), .RST_N(rst_n), .REQ(req), .MASK(mask), .ACK(ack), .ACK_ID(ack_id),
        .IRQ3(irq3_e), .IRQ2(irq2_e), .IRQ1(irq1_e), .PEND(pend_e), .OVF(ovf_e), .ANY(any_e)
    );

    irq_latch #(.SYNC_STAGES(2), .EDGE_MODE(1'b0)) u_dut_level (
        .CLK(clk), .RST_N(rst_n), .REQ(req), .MASK(mask), .ACK(ack), .ACK_ID(ack_id),
        .IRQ3(irq3_l), .IRQ2(irq2_l), .IRQ1(irq1_l), .PEND(pend_l), .OVF(ovf_l), .ANY(any_l)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for the rising edge, then step 1 time unit past it so that both sampling and driving happen away from the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack(input logic [1:0] id);
        ack    = 1'b1;
        ack_id = id;
        tick(1);
        ack    = 1'b0;
        ack_id = 2'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = 3'b000; mask = 3'b000; ack = 1'b0; ack_id = 2'd0;
        tick(2);
        rst_n = 1'b1;
        check("reset_pend", {5'd0, pend_e}, 8'h00);
        check("reset_ovf",  {5'd0, ovf_e},  8'h00);
        check("reset_any",  {7'd0, any_e},  8'h00);

        // Hold line 3 high and acknowledge it. It must not trigger again.
        mask = 3'b111; req = 3'b100;
        tick(2);
        check("lat_irq3_early", {7'd0, irq3_e}, 8'h00);
        tick(1);
        check("lat_irq3_3rd", {7'd0, irq3_e}, 8'h01);
        tick(3);
        check("held_irq3", {7'd0, irq3_e}, 8'h01);
        pulse_ack(2'd3);
        check("ack3_irq3", {7'd0, irq3_e}, 8'h00);
        tick(3);
        check("no_retrig", {5'd0, pend_e}, 8'h00);
        req = 3'b000;
        tick(3);

        // Check that line 1 and line 2 are held pending together.
        req = 3'b001; tick(1);
        req = 3'b010; tick(1);
        req = 3'b000; tick(4);
        check("order_pend", {5'd0, pend_e}, 8'h03);
        check("order_irq", {5'd0, irq3_e, irq2_e, irq1_e}, 8'h03);
        pulse_ack(2'd2);
        check("order_ack2", {5'd0, pend_e}, 8'h01);
        pulse_ack(2'd0);
        check("ackid0_ign", {5'd0, pend_e}, 8'h01);
        pulse_ack(2'd3);
        check("ack_notpend", {5'd0, pend_e}, 8'h01);
        pulse_ack(2'd1);
        check("order_ack1", {5'd0, pend_e}, 8'h00);

        // Two events on line 1 with no ACK between them cause an overrun.
        req = 3'b001; tick(1);
        req = 3'b000; tick(1);
        req = 3'b001; tick(1);
        req = 3'b000; tick(4);
        check("ovf_pend", {5'd0, pend_e}, 8'h01);
        check("ovf_set",  {5'd0, ovf_e},  8'h01);
        pulse_ack(2'd1);
        check("ovf_clr_pend", {5'd0, pend_e}, 8'h00);
        check("ovf_clr_ovf",  {5'd0, ovf_e},  8'h00);

        // A rise on line 2 in the same cycle as its ACK.
        req = 3'b010; tick(1);
        req = 3'b000; tick(4);
        check("same_pre", {5'd0, pend_e}, 8'h02);
        req = 3'b010; tick(1);
        req = 3'b000; tick(1);
        pulse_ack(2'd2);
        check("same_pend", {5'd0, pend_e}, 8'h02);
        check("same_ovf",  {5'd0, ovf_e},  8'h00);
        pulse_ack(2'd2);
        check("same_clr", {5'd0, pend_e}, 8'h00);

        // A masked line is still latched. Unmasking it shows the IRQ at once.
        mask = 3'b011;
        req = 3'b100; tick(1);
        req = 3'b000; tick(4);
        check("mask_pend", {5'd0, pend_e}, 8'h04);
        check("mask_irq3", {7'd0, irq3_e}, 8'h00);
        check("mask_any",  {7'd0, any_e},  8'h00);
        mask = 3'b111;
        #1;
        check("unmask_irq3", {7'd0, irq3_e}, 8'h01);
        check("unmask_any",  {7'd0, any_e},  8'h01);

        // Build PEND=111 and OVF=010, then reset in the middle of operation.
        req = 3'b011; tick(1);
        req = 3'b000; tick(1);
        req = 3'b010; tick(1);
        req = 3'b000; tick(4);
        check("pre_rst_pend", {5'd0, pend_e}, 8'h07);
        check("pre_rst_ovf",  {5'd0, ovf_e},  8'h02);
        do_reset();
        check("rst_pend", {5'd0, pend_e}, 8'h00);
        check("rst_ovf",  {5'd0, ovf_e},  8'h00);
        check("rst_irqs", {4'd0, any_e, irq3_e, irq2_e, irq1_e}, 8'h00);

        // Level mode: PEND follows the synchronised lines, and ACK has no effect.
        req = 3'b111;
        tick(2);
        check("lvl_early", {5'd0, pend_l}, 8'h00);
        tick(1);
        check("lvl_high", {5'd0, pend_l}, 8'h07);
        pulse_ack(2'd1);
        check("lvl_ack_ign", {5'd0, pend_l}, 8'h07);
        check("lvl_ovf", {5'd0, ovf_l}, 8'h00);
        req = 3'b000;
        tick(2);
        check("lvl_hold", {5'd0, pend_l}, 8'h07);
        tick(1);
        check("lvl_low", {5'd0, pend_l}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/irq_latch.md
Name: irq_latch

Overview:
- Front-end stage for the IRQ priority encoder.
- Synchronises three asynchronous interrupt request lines and captures them as pending flags, either edge- or level-sensitive.
- Presents the masked pending flags on IRQ3/IRQ2/IRQ1, which connect straight to the encoder inputs.
- Clears a pending flag when the consumer acknowledges it with the encoded number the encoder produced.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops per request line; legal range 2..4.
- EDGE_MODE, 1: 1 = rising-edge capture into a sticky pending flag; 0 = level mode, where pending follows the synchronised line.

Ports:
- CLK  input  1  single clock for all state.
- RST_N  input  1  synchronous, active-low reset.
- REQ  input  3  asynchronous requests; REQ[2] is line 3, REQ[1] is line 2, REQ[0] is line 1.
- MASK  input  3  per-line enable, same bit order; 1 = line presented on its IRQx output.
- ACK  input  1  single-cycle acknowledge strobe.
- ACK_ID  input  2  line being acknowledged (1..3), same encoding as ENC.
- IRQ3  output  1  pending[2] & MASK[2]; drives the encoder.
- IRQ2  output  1  pending[1] & MASK[1].
- IRQ1  output  1  pending[0] & MASK[0].
- PEND  output  3  raw pending flags, unmasked.
- OVF  output  3  per-line overrun flag, sticky.
- ANY  output  1  OR of IRQ3, IRQ2, IRQ1.

Behaviour:
- Reset: RST_N sampled low at a rising CLK edge clears all synchroniser flops, the edge-history register, pending and OVF.
  - All outputs are 0 in the cycle after the reset edge.
  - Reset mid-operation discards pending events and overruns.
- Synchroniser: each REQ bit passes through SYNC_STAGES flops; s[i] is the last stage.
- Edge detect (EDGE_MODE=1):
  - rise[i] = s[i] & ~h[i], where h is s delayed one cycle.
  - h resets to 0, so a REQ held high through reset produces exactly one event after release.
- Latency: REQ first sampled high at edge k gives PEND high after edge k+SYNC_STAGES. With the default that is 3 edges including k.
- Per-line pending update, EDGE_MODE=1, evaluated each edge (clr[i] = ACK & ACK_ID==i+1):
  - rise & ~pend -> pend<=1.
  - rise & pend & ~clr -> pend stays 1, OVF[i]<=1.
  - rise & clr -> pend stays 1, OVF unchanged. The new event replaces the acknowledged one; no overrun.
  - clr & ~rise -> pend<=0, OVF[i]<=0.
  - Otherwise hold.
- EDGE_MODE=0: pend<=s each cycle. ACK has no effect. OVF is constant 0.
- ACK rules:
  - ACK_ID=0 is ignored.
  - ACK on a line that is not pending is ignored; OVF is unchanged.
  - ACK may clear a masked line.
  - Only one line is cleared per cycle.
- MASK is combinational on IRQx and ANY only.
  - Masked events still set pend and OVF.
  - Unmasking a pending line raises its IRQx in the same cycle.
- Outputs IRQx, ANY: combinational from registered pend and MASK. PEND and OVF are driven directly from registers.
- A REQ pulse shorter than one CLK period may be missed. A new event requires REQ low for at least one sampled cycle.

Test Plan:
- Reset, then MASK=111 and REQ=100 held → IRQ3=1 after the 3rd edge and stays 1 with REQ still high; ACK with ACK_ID=3 → IRQ3=0 the next cycle and no re-trigger while REQ stays high.
- Pending ordering: REQ=001 pulse, then REQ=010 pulse, with no ACK → PEND=011 and IRQ2=IRQ1=1 (encoder output 2); ACK with ACK_ID=2 → PEND=001 (encoder output 1).
- Overrun: two REQ[0] pulses with no ACK → OVF=001; ACK with ACK_ID=1 → PEND=000 and OVF=000.
- Same-cycle ACK and edge on line 2 → PEND[1] stays 1 and OVF[1] stays 0.
- MASK=011 with REQ=100 pulse → PEND=100, IRQ3=0, ANY=0; set MASK=111 → IRQ3=1 and ANY=1 in the same cycle.
- RST_N low for one edge while PEND=111 and OVF=010 → all outputs 0 next cycle.
- EDGE_MODE=0: REQ=111 → PEND=111 after 3 edges; REQ=000 → PEND=000 after 3 edges; ACK has no effect.
